lzw_encode_ctrl: RTL and testbench

LZW encoder front-end that sits directly upstream of the dictionary CAM. It accepts a byte stream over a valid/ready handshake and tracks the current prefix code. For each new byte it issues one CAM lookup of (prefix, byte). A hit extends the prefix; a miss emits the prefix as an output code and restarts the prefix from that byte. It mirrors the CAM's dictionary size so it can classify each CAM result as hit or miss.

---
 rtl/lzw_encode_ctrl.sv | 112 +++++++++++
 tb/tb_lzw_encode_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzw_encode_ctrl.sv
// rtl/lzw_encode_ctrl.sv - LZW encoder prefix tracker feeding the dictionary CAM
module lzw_encode_ctrl #(
  parameter int LOGD = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGD-1:0] out_code,
  output logic            out_last,
  output logic            cam_fire,
  output logic [LOGD-1:0] cam_code,
  output logic [7:0]      cam_c,
  input  logic            cam_busy,
  input  logic            cam_valid,
  input  logic [LOGD:0]   cam_encoding
);

  typedef enum logic [1:0] {EMPTY, HAVE, WAIT, FLUSH} state_t;

  localparam logic [LOGD:0] DEPTH      = {1'b1, {LOGD{1'b0}}};
  localparam logic [LOGD:0] FIRST_CODE = (LOGD+1)'(258);

  state_t          state;
  logic [LOGD-1:0] prefix;
  logic [LOGD:0]   dict_size;
  logic            last_q;
  logic [7:0]      c_q;
  logic            accept;
  logic            cam_hit;

  assign in_ready = (state == EMPTY || state == HAVE) && !cam_busy && !out_valid;
  assign accept   = in_valid && in_ready;
  assign cam_fire = (state == HAVE) && accept;
  assign cam_code = prefix;
  assign cam_c    = in_data;
  // Codes at or beyond our mirrored size are the CAM's "new entry" answers.
  assign cam_hit  = cam_encoding < dict_size;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      prefix    <= '0;
      dict_size <= FIRST_CODE;
      last_q    <= 1'b0;
      c_q       <= 8'd0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        EMPTY: begin
          if (accept) begin
            prefix <= LOGD'(in_data);
            if (in_last) begin
              out_code  <= LOGD'(in_data);
              out_last  <= 1'b1;
              out_valid <= 1'b1;
            end else begin
              state <= HAVE;
            end
          end
        end
        HAVE: begin
          if (accept) begin
            c_q    <= in_data;
            last_q <= in_last;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cam_valid) begin
            if (cam_hit) begin
              prefix <= cam_encoding[LOGD-1:0];
              if (last_q) begin
                out_code  <= cam_encoding[LOGD-1:0];
                out_last  <= 1'b1;
                out_valid <= 1'b1;
                state     <= EMPTY;
              end else begin
                state <= HAVE;
              end
            end else begin
              out_code  <= prefix;
              out_last  <= 1'b0;
              out_valid <= 1'b1;
              prefix    <= LOGD'(c_q);
              // A full dictionary stops growing; the CAM keeps answering DEPTH.
              if (dict_size < DEPTH) dict_size <= dict_size + 1'b1;
              state <= last_q ? FLUSH : HAVE;
            end
          end
        end
        FLUSH: begin
          if (out_valid && out_ready) begin
            out_code  <= prefix;
            out_last  <= 1'b1;
            out_valid <= 1'b1;
            state     <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_lzw_encode_ctrl.sv
// tb/tb_lzw_encode_ctrl.sv - self-checking bench for lzw_encode_ctrl against a software LZW model
module tb_lzw_encode_ctrl;

  localparam int LOGD  = 9;
  localparam int DEPTH = 1 << LOGD;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [LOGD-1:0] out_code;
  logic            out_last;
  logic            cam_fire;
  logic [LOGD-1:0] cam_code;
  logic [7:0]      cam_c;
  logic            cam_busy;
  logic            cam_valid;
  logic [LOGD:0]   cam_encoding;

  lzw_encode_ctrl #(.LOGD(LOGD)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_last(out_last),
    .cam_fire(cam_fire), .cam_code(cam_code), .cam_c(cam_c),
    .cam_busy(cam_busy), .cam_valid(cam_valid), .cam_encoding(cam_encoding)
  );

  always #5 clk = ~clk;

  // kind: 0 = follows a lookup (5 cycles after accept), 1 = flushed after consume, 2 = single-byte stream
  int exp_code[$];
  int exp_last[$];
  int exp_kind[$];
  int got_code[$];
  int got_last[$];
  int model_dict[int];
  int model_size;
  int cam_dict[int];
  int cam_size;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fire_cnt = 0;
  int full_resp_cnt = 0;
  int last_accept_cyc = 0;
  int last_consume_cyc = 0;
  bit bp_done;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_exp(input int code, input int last, input int kind);
    exp_code.push_back(code);
    exp_last.push_back(last);
    exp_kind.push_back(kind);
  endfunction

  // Plain textbook LZW over the whole stream.
  function automatic void model_encode(input int b[$]);
    int w;
    int key;
    if (b.size() == 1) begin
      push_exp(b[0], 1, 2);
      return;
    end
    w = b[0];
    for (int i = 1; i < b.size(); i++) begin
      key = w * 256 + b[i];
      if (model_dict.exists(key)) begin
        w = model_dict[key];
        if (i == b.size() - 1) push_exp(w, 1, 0);
      end else begin
        push_exp(w, 0, 0);
        if (model_size < DEPTH) begin
          model_dict[key] = model_size;
          model_size++;
        end
        w = b[i];
        if (i == b.size() - 1) push_exp(w, 1, 1);
      end
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // CAM stand-in: miss answers with its current size and adds the entry unless full.
  initial begin
    int key;
    int res;
    cam_busy = 1'b0;
    cam_valid = 1'b0;
    cam_encoding = '0;
    forever begin
      @(negedge clk);
      if (cam_fire && !rst) begin
        key = int'(cam_code) * 256 + int'(cam_c);
        if (cam_dict.exists(key)) begin
          res = cam_dict[key];
        end else begin
          res = cam_size;
          if (cam_size < DEPTH) begin
            cam_dict[key] = cam_size;
            cam_size++;
          end else begin
            full_resp_cnt++;
          end
        end
        @(posedge clk); #1 cam_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cam_valid = 1'b1;
        cam_encoding = (LOGD+1)'(res);
        @(posedge clk); #1;
        cam_valid = 1'b0;
        cam_busy = 1'b0;
      end
    end
  end

  // Compare process: every presented code, hold rules, handshake invariants, latency.
  initial begin
    bit pv, pr;
    int pc, pl, ref_cyc, want_lat;
    bit fresh;
    pv = 0; pr = 0; pc = 0; pl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
        continue;
      end
      if (cam_fire) fire_cnt++;
      if (in_valid && in_ready) last_accept_cyc = cyc;
      if (cam_busy) check("no_fire_while_busy", int'(cam_fire), 0);
      if (out_valid) check("in_ready_low_while_out_valid", int'(in_ready), 0);
      if (pv && !pr) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_code", int'(out_code), pc);
        check("hold_last", int'(out_last), pl);
      end
      fresh = out_valid && !(pv && !pr);
      if (fresh) begin
        got_code.push_back(int'(out_code));
        got_last.push_back(int'(out_last));
        if (exp_code.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_code: got %0d required no output (cycle %0d)", out_code, cyc);
        end else begin
          check("out_code", int'(out_code), exp_code[0]);
          check("out_last", int'(out_last), exp_last[0]);
          ref_cyc  = (exp_kind[0] == 1) ? last_consume_cyc : last_accept_cyc;
          want_lat = (exp_kind[0] == 0) ? 5 : 1;
          check("latency", cyc - ref_cyc, want_lat);
          void'(exp_code.pop_front());
          void'(exp_last.pop_front());
          void'(exp_kind.pop_front());
        end
      end
      if (out_valid && out_ready) last_consume_cyc = cyc;
      pv = out_valid; pr = out_ready; pc = int'(out_code); pl = int'(out_last);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d codes outstanding", exp_code.size());
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input int b, input bit last);
    int n;
    in_valid = 1'b1;
    in_data  = 8'(b);
    in_last  = last;
    n = 0;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: byte %0d not accepted, required within 200 cycles", b);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~8'(b);
    in_last  = !last;
  endtask

  task automatic send_stream(input int b[$]);
    model_encode(b);
    for (int i = 0; i < b.size(); i++) send_byte(b[i], i == b.size() - 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_code.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({name, "_drained"}, exp_code.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_log(input string name, input int codes[$], input int lasts[$]);
    check({name, "_count"}, got_code.size(), codes.size());
    for (int i = 0; i < codes.size() && i < got_code.size(); i++) begin
      check({name, "_code"}, got_code[i], codes[i]);
      check({name, "_last"}, got_last[i], lasts[i]);
    end
    got_code.delete();
    got_last.delete();
  endtask

  task automatic fresh_reset();
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_code", int'(out_code), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_cam_fire", int'(cam_fire), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cam_dict.delete();
    model_dict.delete();
    cam_size = 258;
    model_size = 258;
    got_code.delete();
    got_last.delete();
  endtask

  initial begin
    int s[$];
    int ec[$];
    int el[$];
    int fc;
    int n;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'd0;
    in_last = 1'b0;
    out_ready = 1'b1;
    fresh_reset();

    // Reset while a lookup is outstanding; the late cam_valid must be ignored.
    send_byte('h58, 1'b0);
    send_byte('h59, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("wait_rst_out_valid", int'(out_valid), 0);
    repeat (6) @(negedge clk);
    check("wait_rst_out_valid_late", int'(out_valid), 0);
    check("wait_rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    cam_dict.delete();
    cam_size = 258;

    s = '{'h41, 'h42};
    send_stream(s);
    drain("ab");
    ec = '{'h41, 'h42}; el = '{0, 1};
    check_log("ab", ec, el);

    s = '{'h41, 'h42, 'h41, 'h42};
    send_stream(s);
    drain("abab");
    ec = '{258, 258}; el = '{0, 1};
    check_log("abab", ec, el);

    fc = fire_cnt;
    s = '{'h7F};
    send_stream(s);
    drain("single");
    ec = '{'h7F}; el = '{1};
    check_log("single", ec, el);
    check("single_no_cam_fire", fire_cnt, fc);

    // Backpressure: first code held for 10 cycles.
    out_ready = 1'b0;
    bp_done = 1'b0;
    s = '{'h43, 'h44, 'h45};
    fork
      begin
        send_stream(s);
        bp_done = 1'b1;
      end
    join_none
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", int'(out_valid), 1);
    fc = fire_cnt;
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_code", int'(out_code), 'h43);
    end
    check("bp_no_cam_fire", fire_cnt, fc);
    @(posedge clk); #1 out_ready = 1'b1;
    n = 0;
    while (!bp_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_stream_done", int'(bp_done), 1);
    drain("bp");
    ec = '{'h43, 'h44, 'h45}; el = '{0, 0, 1};
    check_log("bp", ec, el);

    // Fill the dictionary, then keep missing against a full one.
    s.delete();
    for (int i = 0; i < 256; i++) s.push_back(i);
    send_stream(s);
    drain("fill_up");
    s.delete();
    for (int i = 255; i >= 0; i--) s.push_back(i);
    send_stream(s);
    drain("fill_full");
    check("model_dict_full", model_size, DEPTH);
    check("cam_full_answers_seen", int'(full_resp_cnt > 200), 1);
    got_code.delete();
    got_last.delete();

    // Reset must bring dict_size back to 258: 258 is a miss again.
    fresh_reset();
    s = '{'h41, 'h42};
    send_stream(s);
    drain("ab_after_full");
    ec = '{'h41, 'h42}; el = '{0, 1};
    check_log("ab_after_full", ec, el);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
